// File: rtl/reg_pipe_skid.sv
// Two-entry valid/ready register slice (skid buffer); every output is driven straight from a flop.
// Optional synchronous flush is compiled in when REG_SKID_FLUSH_EN is defined.
module reg_pipe_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
`ifdef REG_SKID_FLUSH_EN
    input  logic                  i_flush,
`endif
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_skid;

    logic w_inFire;
    logic w_outFire;
    logic w_flush;
    logic w_loadOut;
    logic w_outFromSkid;
    logic w_loadSkid;

    assign w_inFire  = i_valid & r_ready;
    assign w_outFire = r_valid & i_ready;

`ifdef REG_SKID_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_stateNext   = r_state;
        w_loadOut     = 1'b0;
        w_outFromSkid = 1'b0;
        w_loadSkid    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_inFire) begin
                    w_stateNext = BUSY;
                    w_loadOut   = 1'b1;
                end
            end
            BUSY: begin
                if (w_inFire && !w_outFire) begin
                    w_stateNext = FULL;
                    w_loadSkid  = 1'b1;
                end else if (!w_inFire && w_outFire) begin
                    w_stateNext = EMPTY;
                end else if (w_inFire && w_outFire) begin
                    w_loadOut = 1'b1;
                end
            end
            FULL: begin
                if (w_outFire) begin
                    w_stateNext   = BUSY;
                    w_loadOut     = 1'b1;
                    w_outFromSkid = 1'b1;
                end
            end
            default: w_stateNext = EMPTY;
        endcase
        // Flush wins over any concurrent transfer; the incoming beat is dropped.
        if (w_flush) begin
            w_stateNext = EMPTY;
            w_loadOut   = 1'b0;
            w_loadSkid  = 1'b0;
        end
    end

    // Ready and valid are registered from the next state so no output depends on inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ready <= (w_stateNext != FULL);
            r_valid <= (w_stateNext != EMPTY);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadOut) begin
                r_out <= w_outFromSkid ? r_skid : i_data;
            end
            if (w_loadSkid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_out;
    assign o_count = r_state;

endmodule
